mux_scan: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_if.sv | 22 ++
 rtl/key_mux.sv | 22 ++
 rtl/mux_scan_next.sv | 39 +++
 rtl/mux_scan.sv | 113 +++++++++++
 tb/tb_mux_scan.sv | 281 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the mux_scan slice: FSM state encoding and mode constants.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_if.sv
// Channel bus, controls and selected-word outputs of mux_scan.
// master drives channels/controls, slave (the selector) drives the outputs.
interface mux_scan_if #(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 8,
  parameter int SEL_LEN  = 2
);
  logic [NR_CH*DATA_LEN-1:0] din;
  logic                      en;
  logic                      mode;
  logic [SEL_LEN-1:0]        sel;
  logic [NR_CH-1:0]          ch_mask;
  logic [DATA_LEN-1:0]       y;
  logic                      y_valid;
  logic [SEL_LEN-1:0]        cur_ch;
  logic                      ch_wrap;

  modport master (output din, en, mode, sel, ch_mask,
                  input  y, y_valid, cur_ch, ch_wrap);
  modport slave  (input  din, en, mode, sel, ch_mask,
                  output y, y_valid, cur_ch, ch_wrap);
endinterface

// File: rtl/key_mux.sv
// Keyed mux: outputs the data word whose key matches, DEFAULT when no key matches.
// Combinational, zero latency; no flow control.
module key_mux #(
  parameter int                  NR_KEYS  = 4,
  parameter int                  KEY_LEN  = 2,
  parameter int                  DATA_LEN = 8,
  parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
  input  logic [KEY_LEN-1:0]          key,
  input  logic [NR_KEYS*KEY_LEN-1:0]  keys,
  input  logic [NR_KEYS*DATA_LEN-1:0] data,
  output logic [DATA_LEN-1:0]         dout
);

  always_comb begin
    dout = DEFAULT;
    for (int i = 0; i < NR_KEYS; i++) begin
      if (keys[i*KEY_LEN +: KEY_LEN] == key) dout = data[i*DATA_LEN +: DATA_LEN];
    end
  end

endmodule

// File: rtl/mux_scan_next.sv
// Cyclic priority search: lowest enabled channel above cur_ch, else lowest enabled (wrap).
// Combinational, zero latency; no flow control.
module mux_scan_next #(
  parameter int NR_CH   = 4,
  parameter int SEL_LEN = 2
) (
  input  logic [NR_CH-1:0]   ch_mask,
  input  logic [SEL_LEN-1:0] cur_ch,
  output logic [SEL_LEN-1:0] nxt_ch,
  output logic               wrap,
  output logic               any_en
);

  logic               found;
  logic [SEL_LEN-1:0] lowest;

  always_comb begin
    found  = 1'b0;
    lowest = '0;
    nxt_ch = cur_ch;
    wrap   = 1'b0;
    any_en = |ch_mask;
    for (int i = NR_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lowest = SEL_LEN'(i);
    end
    // cur_ch may exceed NR_CH-1 after manual mode; then nothing lies above it
    for (int i = 0; i < NR_CH; i++) begin
      if (!found && ch_mask[i] && (i > int'(cur_ch))) begin
        nxt_ch = SEL_LEN'(i);
        found  = 1'b1;
      end
    end
    if (!found && any_en) begin
      nxt_ch = lowest;
      wrap   = 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel selector with manual select and round-robin scan with dwell.
// Latency 1 cycle; no backpressure, en=0 freezes all state and drops y_valid.
module mux_scan #(
  parameter int                  NR_CH    = 4,
  parameter int                  DATA_LEN = 8,
  parameter int                  SEL_LEN  = 2,
  parameter int                  DWELL    = 4,
  parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.slave  bus
);
  import mux_scan_pkg::*;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t                   state;
  logic                     scan_held;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [SEL_LEN-1:0]       cur_ch_q, ch_d, nxt_ch;
  logic [DATA_LEN-1:0]      y_q, sel_dat;
  logic                     y_valid_q, ch_wrap_q;
  logic                     nxt_wrap, any_en, cur_en, scan_cont, vld_d, wrap_d;
  logic [NR_CH*SEL_LEN-1:0] keys;

  mux_scan_next #(.NR_CH(NR_CH), .SEL_LEN(SEL_LEN)) u_next (
    .ch_mask (bus.ch_mask),
    .cur_ch  (cur_ch_q),
    .nxt_ch  (nxt_ch),
    .wrap    (nxt_wrap),
    .any_en  (any_en)
  );

  always_comb begin
    cur_en = 1'b0;
    for (int i = 0; i < NR_CH; i++) begin
      if (int'(cur_ch_q) == i) cur_en = bus.ch_mask[i];
    end
  end

  // A scan is in progress if it was live when en dropped, or live last cycle
  assign scan_cont = (state == ST_OFF) ? scan_held : ((state == ST_SCAN) && y_valid_q);

  always_comb begin
    ch_d   = cur_ch_q;
    cnt_d  = '0;
    wrap_d = 1'b0;
    vld_d  = 1'b0;
    if (bus.mode == MODE_MANUAL) begin
      ch_d  = bus.sel;
      vld_d = (int'(bus.sel) < NR_CH);
    end else if (any_en) begin
      vld_d = 1'b1;
      if (!cur_en) begin
        ch_d   = nxt_ch;
        wrap_d = scan_cont && nxt_wrap;
      end else if (scan_cont && (cnt == CNT_W'(DWELL - 1))) begin
        ch_d   = nxt_ch;
        wrap_d = nxt_wrap;
      end else if (scan_cont) begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NR_CH; k++) begin : g_keys
    assign keys[k*SEL_LEN +: SEL_LEN] = SEL_LEN'(k);
  end

  key_mux #(
    .NR_KEYS (NR_CH),
    .KEY_LEN (SEL_LEN),
    .DATA_LEN(DATA_LEN),
    .DEFAULT (DEFAULT)
  ) u_mux (
    .key  (ch_d),
    .keys (keys),
    .data (bus.din),
    .dout (sel_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      scan_held <= 1'b0;
      cnt       <= '0;
      cur_ch_q  <= '0;
      y_q       <= DEFAULT;
      y_valid_q <= 1'b0;
      ch_wrap_q <= 1'b0;
    end else if (!bus.en) begin
      state     <= ST_OFF;
      scan_held <= scan_cont;
      y_valid_q <= 1'b0;
      ch_wrap_q <= 1'b0;
    end else begin
      state     <= (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      scan_held <= 1'b0;
      cnt       <= cnt_d;
      cur_ch_q  <= ch_d;
      y_q       <= vld_d ? sel_dat : DEFAULT;
      y_valid_q <= vld_d;
      ch_wrap_q <= wrap_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.cur_ch  = cur_ch_q;
  assign bus.ch_wrap = ch_wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: expected words queued at drive time, popped after each edge.
module tb_mux_scan;
  localparam int         NR_CH    = 4;
  localparam int         DATA_LEN = 8;
  localparam int         SEL_LEN  = 3;
  localparam int         DWELL    = 4;
  localparam logic [7:0] DEF      = 8'hE7;

  typedef struct packed {
    logic [7:0] y;
    logic       vld;
    logic [2:0] ch;
    logic       wrap;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_scan_if #(.NR_CH(NR_CH), .DATA_LEN(DATA_LEN), .SEL_LEN(SEL_LEN)) bus ();

  mux_scan #(
    .NR_CH(NR_CH), .DATA_LEN(DATA_LEN), .SEL_LEN(SEL_LEN), .DWELL(DWELL), .DEFAULT(DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] dfix = 32'h44332211;

  function automatic obs_t observe();
    obs_t o;
    o.y = bus.y; o.vld = bus.y_valid; o.ch = bus.cur_ch; o.wrap = bus.ch_wrap;
    return o;
  endfunction

  function automatic logic [7:0] chan(input logic [31:0] d, input int ch);
    return d[ch*8 +: 8];
  endfunction

  function automatic obs_t mk(input logic [7:0] y, input logic v, input int ch, input logic w);
    obs_t o;
    o.y = y; o.vld = v; o.ch = 3'(ch); o.wrap = w;
    return o;
  endfunction

  task automatic drive(input logic en, input logic mode, input int sel,
                       input logic [3:0] mask, input logic [31:0] d);
    bus.en = en; bus.mode = mode; bus.sel = 3'(sel); bus.ch_mask = mask; bus.din = d;
  endtask

  task automatic test_reset();
    obs_t got, want;
    drive(1'b1, 1'b0, 2, 4'b1111, dfix);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(DEF, 1'b0, 0, 1'b0));
      if (i == 0) #1; else begin @(posedge clk); #1; end
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 i, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    obs_t got, want;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b0, s, 4'b0000, dfix);
      exp_q.push_back(mk(chan(dfix, s), 1'b1, s, 1'b0));
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL manual[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 s, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Out-of-range selects, then scan entry from index 7 (nothing above it, so wraps to ch 1)
  task automatic test_sel_oor();
    obs_t got, want;
    int   sels[3] = '{4, 5, 7};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        drive(1'b1, 1'b0, sels[i], 4'b1111, dfix);
        exp_q.push_back(mk(DEF, 1'b0, sels[i], 1'b0));
      end else begin
        drive(1'b1, 1'b1, 0, 4'b0110, dfix);
        exp_q.push_back(mk(chan(dfix, (i < 7) ? 1 : 2), 1'b1, (i < 7) ? 1 : 2, 1'b0));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sel_oor[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 i, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Mask 1011: ch 0,1,3 each for DWELL cycles, wrap when returning to 0; data is live
  task automatic test_scan();
    obs_t        got, want;
    int          seq[3] = '{0, 1, 3};
    int          ch;
    logic [31:0] d;
    for (int t = -1; t < 26; t++) begin
      d = $urandom;
      if (t < 0) begin
        drive(1'b1, 1'b0, 0, 4'b1011, d);
        exp_q.push_back(mk(chan(d, 0), 1'b1, 0, 1'b0));
      end else begin
        ch = seq[(t / DWELL) % 3];
        drive(1'b1, 1'b1, 0, 4'b1011, d);
        exp_q.push_back(mk(chan(d, ch), 1'b1, ch, (t % 12 == 0) && (t != 0)));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scan[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Clear ch 1 at its dwell count 1: jump to 3 at once, full dwell there, then wrap to 0
  task automatic test_mask_drop();
    obs_t got, want;
    int   ch;
    for (int t = -1; t < 11; t++) begin
      if (t < 0) begin
        drive(1'b1, 1'b0, 0, 4'b1011, dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b1, 0, 1'b0));
      end else if (t < 6) begin
        ch = (t < 4) ? 0 : 1;
        drive(1'b1, 1'b1, 0, 4'b1011, dfix);
        exp_q.push_back(mk(chan(dfix, ch), 1'b1, ch, 1'b0));
      end else begin
        ch = (t < 10) ? 3 : 0;
        drive(1'b1, 1'b1, 0, 4'b1001, dfix);
        exp_q.push_back(mk(chan(dfix, ch), 1'b1, ch, t == 10));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mask_drop[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Empty mask gives DEFAULT/invalid; single channel 2 then wraps on itself every DWELL
  task automatic test_no_mask();
    obs_t got, want;
    for (int t = -4; t < 13; t++) begin
      if (t == -4) begin
        drive(1'b1, 1'b0, 0, 4'b0000, dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b1, 0, 1'b0));
      end else if (t < 0) begin
        drive(1'b1, 1'b1, 0, 4'b0000, dfix);
        exp_q.push_back(mk(DEF, 1'b0, 0, 1'b0));
      end else begin
        drive(1'b1, 1'b1, 0, 4'b0100, dfix);
        exp_q.push_back(mk(chan(dfix, 2), 1'b1, 2, (t % DWELL == 0) && (t != 0)));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL no_mask[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Mode and mask change together: entry uses the new mask (ch 1 masked, start at 2)
  task automatic test_mode_mask();
    obs_t got, want;
    for (int t = -1; t < 5; t++) begin
      if (t < 0) begin
        drive(1'b1, 1'b0, 1, 4'b0010, dfix);
        exp_q.push_back(mk(chan(dfix, 1), 1'b1, 1, 1'b0));
      end else begin
        drive(1'b1, 1'b1, 1, 4'b0100, dfix);
        exp_q.push_back(mk(chan(dfix, 2), 1'b1, 2, t == 4));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mode_mask[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // en low for 3 cycles after 2 dwell cycles on ch 0: hold, then 2 more on ch 0
  task automatic test_en_freeze();
    obs_t got, want;
    int   ch;
    for (int t = -1; t < 11; t++) begin
      if (t < 0) begin
        drive(1'b1, 1'b0, 0, 4'b1111, dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b1, 0, 1'b0));
      end else if (t < 2) begin
        drive(1'b1, 1'b1, 0, 4'b1111, dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b1, 0, 1'b0));
      end else if (t < 5) begin
        drive(1'b0, 1'b1, 0, 4'b1111, ~dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b0, 0, 1'b0));
      end else begin
        ch = (t < 7) ? 0 : 1;
        drive(1'b1, 1'b1, 0, 4'b1111, dfix);
        exp_q.push_back(mk(chan(dfix, ch), 1'b1, ch, 1'b0));
      end
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL en_freeze[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  // Reset pulse while on ch 1 mid-dwell; afterwards scan restarts fresh on ch 0
  task automatic test_reset_mid();
    obs_t got, want;
    int   ch;
    for (int t = -1; t < 14; t++) begin
      if (t < 0) begin
        drive(1'b1, 1'b0, 0, 4'b1111, dfix);
        exp_q.push_back(mk(chan(dfix, 0), 1'b1, 0, 1'b0));
      end else if (t < 6) begin
        ch = (t < 4) ? 0 : 1;
        drive(1'b1, 1'b1, 0, 4'b1111, dfix);
        exp_q.push_back(mk(chan(dfix, ch), 1'b1, ch, 1'b0));
      end else if (t < 8) begin
        exp_q.push_back(mk(DEF, 1'b0, 0, 1'b0));
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
        ch = (t < 12) ? 0 : 1;
        exp_q.push_back(mk(chan(dfix, ch), 1'b1, ch, 1'b0));
      end
      if (t == 6) #2; else begin @(posedge clk); #1; end
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d] got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                 t, got.y, got.vld, got.ch, got.wrap, want.y, want.vld, want.ch, want.wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_sel_oor();
    test_scan();
    test_mask_drop();
    test_no_mask();
    test_mode_mask();
    test_en_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
